spi_controller: RTL and testbench

SPI controller (mode 0) that drives the other end of the onboarding SPI register peripheral. It accepts register write/read commands over a valid/ready handshake and serializes each as a 16-bit frame on nCS/SCLK/COPI. For reads it captures CIPO and returns the data. It is used as an on-chip bring-up master and as the stimulus engine for the peripheral's bench.

---
 rtl/spi_ctrl_pkg.sv | 32 +++
 rtl/spi_clk_div.sv | 34 +++
 rtl/spi_controller.sv | 193 +++++++++++++++++++
 tb/tb_spi_controller.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module  : spi_ctrl_pkg
// Brief   : Shared types, widths and frame helper for the SPI mode-0 controller.
// Revision: 1.0 - initial release
// ============================================================================
package spi_ctrl_pkg;

  localparam int FRAME_W = 16;
  localparam int RW_BIT  = 15;
  localparam int ADDR_W  = 7;
  localparam int DATA_W  = 8;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    SHIFT = 3'd2,
    HOLD  = 3'd3,
    GAP   = 3'd4
  } state_t;

  // Reads carry a zero data byte regardless of what sits on the wdata bus.
  function automatic logic [FRAME_W-1:0] build_frame(
    input logic              rw,
    input logic [ADDR_W-1:0] addr,
    input logic [DATA_W-1:0] wdata
  );
    return {rw, addr, (rw ? wdata : {DATA_W{1'b0}})};
  endfunction

endpackage : spi_ctrl_pkg
`default_nettype wire

// File: rtl/spi_clk_div.sv
`default_nettype none
// ============================================================================
// Module  : spi_clk_div
// Brief   : Half-period tick generator; restarts its phase whenever disabled.
// Revision: 1.0 - initial release
// ============================================================================
module spi_clk_div #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic i_en,
  output logic o_tick
);

  localparam int             CNT_W    = $clog2(CLK_DIV) + 1;
  localparam logic [CNT_W-1:0] C_RELOAD = CNT_W'(CLK_DIV - 1);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (rst || !i_en) begin
      r_cnt <= C_RELOAD;
    end else if (r_cnt == '0) begin
      r_cnt <= C_RELOAD;
    end else begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_tick = i_en && (r_cnt == '0);

endmodule : spi_clk_div
`default_nettype wire

// File: rtl/spi_controller.sv
`default_nettype none
// ============================================================================
// Module  : spi_controller
// Brief   : SPI mode-0 master serialising 16-bit register write/read frames.
// Revision: 1.0 - initial release
// ============================================================================
module spi_controller
  import spi_ctrl_pkg::*;
#(
  parameter int CLK_DIV = 4,
  parameter int CS_GAP  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_rw,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              busy,
  output logic              ncs,
  output logic              sclk,
  output logic              copi,
  input  logic              cipo
);

  localparam int               GAP_W      = (CS_GAP > 1) ? $clog2(CS_GAP) : 1;
  localparam logic [GAP_W-1:0] C_GAP_LOAD = GAP_W'((CS_GAP > 0) ? (CS_GAP - 1) : 0);
  localparam logic [4:0]       C_LAST_EDGE = 5'd31;

  state_t              r_state, w_state_nxt;
  logic [FRAME_W-1:0]  r_tx_sr, w_tx_sr_nxt;
  logic [DATA_W-1:0]   r_rx_sr, w_rx_sr_nxt;
  logic                r_rw, w_rw_nxt;
  logic [4:0]          r_edge_cnt, w_edge_cnt_nxt;
  logic [GAP_W-1:0]    r_gap_cnt, w_gap_cnt_nxt;
  logic                r_ncs, w_ncs_nxt;
  logic                r_sclk, w_sclk_nxt;
  logic                r_cmd_ready, w_cmd_ready_nxt;
  logic                r_busy, w_busy_nxt;
  logic                r_rsp_valid, w_rsp_valid_nxt;
  logic [DATA_W-1:0]   r_rsp_rdata, w_rsp_rdata_nxt;
  logic                w_div_en;
  logic                w_tick;

  // The divider runs only while nCS is low so every frame starts with the same phase.
  assign w_div_en = (r_state == SETUP) || (r_state == SHIFT) || (r_state == HOLD);

  spi_clk_div #(
    .CLK_DIV (CLK_DIV)
  ) u_clk_div (
    .clk    (clk),
    .rst    (rst),
    .i_en   (w_div_en),
    .o_tick (w_tick)
  );

  always_comb begin
    w_state_nxt     = r_state;
    w_tx_sr_nxt     = r_tx_sr;
    w_rx_sr_nxt     = r_rx_sr;
    w_rw_nxt        = r_rw;
    w_edge_cnt_nxt  = r_edge_cnt;
    w_gap_cnt_nxt   = r_gap_cnt;
    w_ncs_nxt       = r_ncs;
    w_sclk_nxt      = r_sclk;
    w_cmd_ready_nxt = r_cmd_ready;
    w_busy_nxt      = r_busy;
    w_rsp_valid_nxt = 1'b0;
    w_rsp_rdata_nxt = r_rsp_rdata;

    case (r_state)
      IDLE: begin
        if (cmd_valid && r_cmd_ready) begin
          w_state_nxt     = SETUP;
          w_tx_sr_nxt     = build_frame(cmd_rw, cmd_addr, cmd_wdata);
          w_rw_nxt        = cmd_rw;
          w_rx_sr_nxt     = '0;
          w_edge_cnt_nxt  = '0;
          w_ncs_nxt       = 1'b0;
          w_cmd_ready_nxt = 1'b0;
          w_busy_nxt      = 1'b1;
        end
      end

      SETUP: begin
        // Leaving SETUP is itself the first rising edge (edge index 0).
        if (w_tick) begin
          w_state_nxt    = SHIFT;
          w_sclk_nxt     = 1'b1;
          w_edge_cnt_nxt = 5'd1;
        end
      end

      SHIFT: begin
        if (w_tick) begin
          w_sclk_nxt = ~r_sclk;
          if (r_sclk) begin
            w_tx_sr_nxt = {r_tx_sr[FRAME_W-2:0], 1'b0};
            if (r_edge_cnt == C_LAST_EDGE) begin
              w_state_nxt = HOLD;
            end else begin
              w_edge_cnt_nxt = r_edge_cnt + 5'd1;
            end
          end else begin
            // Even edge index 2k is rising edge k; bit 4 set means k >= 8, the data byte.
            if (r_edge_cnt[4]) begin
              w_rx_sr_nxt = {r_rx_sr[DATA_W-2:0], cipo};
            end
            w_edge_cnt_nxt = r_edge_cnt + 5'd1;
          end
        end
      end

      HOLD: begin
        if (w_tick) begin
          w_ncs_nxt       = 1'b1;
          w_rsp_valid_nxt = 1'b1;
          w_rsp_rdata_nxt = r_rw ? '0 : r_rx_sr;
          if (CS_GAP == 0) begin
            w_state_nxt     = IDLE;
            w_cmd_ready_nxt = 1'b1;
            w_busy_nxt      = 1'b0;
          end else begin
            w_state_nxt   = GAP;
            w_gap_cnt_nxt = C_GAP_LOAD;
          end
        end
      end

      GAP: begin
        if (r_gap_cnt == '0) begin
          w_state_nxt     = IDLE;
          w_cmd_ready_nxt = 1'b1;
          w_busy_nxt      = 1'b0;
        end else begin
          w_gap_cnt_nxt = r_gap_cnt - 1'b1;
        end
      end

      default: begin
        w_state_nxt     = IDLE;
        w_ncs_nxt       = 1'b1;
        w_sclk_nxt      = 1'b0;
        w_cmd_ready_nxt = 1'b1;
        w_busy_nxt      = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_tx_sr     <= '0;
      r_rx_sr     <= '0;
      r_rw        <= 1'b0;
      r_edge_cnt  <= '0;
      r_gap_cnt   <= '0;
      r_ncs       <= 1'b1;
      r_sclk      <= 1'b0;
      r_cmd_ready <= 1'b1;
      r_busy      <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_tx_sr     <= w_tx_sr_nxt;
      r_rx_sr     <= w_rx_sr_nxt;
      r_rw        <= w_rw_nxt;
      r_edge_cnt  <= w_edge_cnt_nxt;
      r_gap_cnt   <= w_gap_cnt_nxt;
      r_ncs       <= w_ncs_nxt;
      r_sclk      <= w_sclk_nxt;
      r_cmd_ready <= w_cmd_ready_nxt;
      r_busy      <= w_busy_nxt;
      r_rsp_valid <= w_rsp_valid_nxt;
      r_rsp_rdata <= w_rsp_rdata_nxt;
    end
  end

  // The shift register MSB is the live COPI bit; it empties to zero by frame end.
  assign copi      = r_tx_sr[RW_BIT];
  assign ncs       = r_ncs;
  assign sclk      = r_sclk;
  assign cmd_ready = r_cmd_ready;
  assign busy      = r_busy;
  assign rsp_valid = r_rsp_valid;
  assign rsp_rdata = r_rsp_rdata;

endmodule : spi_controller
`default_nettype wire

// File: tb/tb_spi_controller.sv
`default_nettype none
// ============================================================================
// Module  : tb_spi_controller
// Brief   : Scoreboard bench with an SPI register-peripheral model on the bus.
// Revision: 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_spi_controller;

  localparam int D = 4;
  localparam int G = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cmd_valid = 1'b0, cmd_rw = 1'b0;
  logic [6:0] cmd_addr = '0;
  logic [7:0] cmd_wdata = '0;
  logic       cmd_ready, rsp_valid, busy, ncs, sclk, copi;
  logic [7:0] rsp_rdata;
  logic       cipo = 1'b0;

  logic       cmd_valid_1 = 1'b0, cmd_rw_1 = 1'b0;
  logic [6:0] cmd_addr_1 = '0;
  logic [7:0] cmd_wdata_1 = '0;
  logic       cmd_ready_1, rsp_valid_1, busy_1, ncs_1, sclk_1, copi_1;
  logic [7:0] rsp_rdata_1;
  logic       cipo_1 = 1'b0;

  always #5 clk = ~clk;

  spi_controller #(.CLK_DIV(D), .CS_GAP(G)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_rw(cmd_rw), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .busy(busy),
    .ncs(ncs), .sclk(sclk), .copi(copi), .cipo(cipo)
  );

  spi_controller #(.CLK_DIV(1), .CS_GAP(0)) dut1 (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid_1), .cmd_ready(cmd_ready_1),
    .cmd_rw(cmd_rw_1), .cmd_addr(cmd_addr_1), .cmd_wdata(cmd_wdata_1),
    .rsp_valid(rsp_valid_1), .rsp_rdata(rsp_rdata_1), .busy(busy_1),
    .ncs(ncs_1), .sclk(sclk_1), .copi(copi_1), .cipo(cipo_1)
  );

  int          n_chk  = 0;
  int          n_fail = 0;
  int unsigned cyc    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic timeout(input string name);
    n_chk++;
    n_fail++;
    $display("FAIL %s: timed out waiting on DUT (cycle %0d)", name, cyc);
  endtask

  // Reference model: peripheral register file plus queues of expected frames/responses.
  logic [7:0]  regs [128];
  logic [15:0] q_frame [$];
  logic [7:0]  q_rdata [$];
  int unsigned q_t [$];

  bit          regs_init = 1'b0;
  logic        prev_ncs = 1'b1, prev_sclk = 1'b0, prev_ready = 1'b1;
  bit          in_frame = 1'b0, skip_ready = 1'b1;
  int          nbits = 0, nfall = 0;
  logic [15:0] rx = '0;
  logic [7:0]  hdr = '0, rv = '0;
  int unsigned last_rsp_cyc = 0;

  always @(negedge clk) begin
    if (rst) begin
      if (!regs_init) begin
        for (int i = 0; i < 128; i++) regs[i] = 8'($urandom);
        regs_init = 1'b1;
      end
      q_frame.delete();
      q_rdata.delete();
      q_t.delete();
      in_frame   = 1'b0;
      skip_ready = 1'b1;
    end else begin
      if (cmd_valid && cmd_ready) begin
        q_frame.push_back({cmd_rw, cmd_addr, (cmd_rw ? cmd_wdata : 8'h00)});
        q_rdata.push_back(cmd_rw ? 8'h00 : regs[cmd_addr]);
        q_t.push_back(cyc);
        skip_ready = 1'b0;
      end
      if (!ncs && prev_ncs) begin
        chk("ncs_fall_pending", 32'(q_t.size()), 32'd1);
        if (q_t.size() > 0) begin
          chk("ncs_fall_cycle", cyc, q_t[0] + 1);
          chk("copi_setup", copi, q_frame[0][15]);
        end
        in_frame = 1'b1;
        nbits    = 0;
        nfall    = 0;
        rx       = '0;
      end
      if (in_frame && !ncs && sclk && !prev_sclk) begin
        if (nbits == 0 && q_t.size() > 0) chk("first_rise_cycle", cyc, q_t[0] + 1 + D);
        rx = {rx[14:0], copi};
        nbits++;
        if (nbits == 8) hdr = rx[7:0];
      end
      if (in_frame && !ncs && !sclk && prev_sclk) begin
        // Peripheral shifts its read byte out on falling edges 7..14.
        if (nfall >= 7 && nfall <= 14) begin
          rv   = regs[hdr[6:0]];
          cipo = hdr[7] ? 1'($urandom) : rv[14 - nfall];
        end
        if (nfall == 15 && q_t.size() > 0) chk("last_fall_cycle", cyc, q_t[0] + 1 + 32 * D);
        nfall++;
      end
      if (ncs && !prev_ncs && in_frame) begin
        in_frame = 1'b0;
        chk("frame_bits", nbits, 16);
        if (q_frame.size() > 0) chk("frame", rx, q_frame[0]);
        if (rx[15]) regs[rx[14:8]] = rx[7:0];
      end
      if (rsp_valid) begin
        chk("rsp_pending", 32'(q_rdata.size() > 0), 32'd1);
        if (q_rdata.size() > 0) begin
          chk("rsp_rdata", rsp_rdata, q_rdata[0]);
          chk("rsp_cycle", cyc, q_t[0] + 1 + 33 * D);
          chk("rsp_ncs_high", ncs, 1'b1);
          void'(q_frame.pop_front());
          void'(q_rdata.pop_front());
          void'(q_t.pop_front());
          last_rsp_cyc = cyc;
        end
      end
      if (cmd_ready && !prev_ready && !skip_ready) chk("ready_cycle", cyc, last_rsp_cyc + G);
    end
    prev_ncs   = ncs;
    prev_sclk  = sclk;
    prev_ready = cmd_ready;
  end

  task automatic send(input logic rw, input logic [6:0] a, input logic [7:0] d, input bit keep);
    bit ok;
    cmd_rw    = rw;
    cmd_addr  = a;
    cmd_wdata = d;
    cmd_valid = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (cmd_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) timeout("send_accept");
    @(posedge clk);
    #1;
    // Scramble the bus: the frame in flight must not notice.
    cmd_rw    = 1'($urandom);
    cmd_addr  = 7'($urandom);
    cmd_wdata = 8'($urandom);
    if (!keep) cmd_valid = 1'b0;
  endtask

  task automatic wait_done();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (q_t.size() == 0 && cmd_ready) begin
        ok = 1'b0 | 1'b1;
        break;
      end
    end
    if (!ok) timeout("wait_done");
  endtask

  initial begin
    int          bad;
    int unsigned t1, last_rise;
    int          nr;
    logic [15:0] fr;
    logic        prev_s;
    bit          ok;
    bit          keep;

    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ncs", ncs, 1'b1);
    chk("rst_sclk", sclk, 1'b0);
    chk("rst_copi", copi, 1'b0);
    chk("rst_cmd_ready", cmd_ready, 1'b1);
    chk("rst_busy", busy, 1'b0);
    chk("rst_rsp_valid", rsp_valid, 1'b0);
    chk("rst_rsp_rdata", rsp_rdata, 8'h00);
    @(posedge clk);
    #1 rst = 1'b0;

    send(1'b1, 7'h00, 8'hF0, 1'b0);
    wait_done();
    send(1'b1, 7'h04, 8'hA5, 1'b0);
    wait_done();
    send(1'b0, 7'h04, 8'h5B, 1'b0);
    wait_done();

    send(1'b1, 7'h01, 8'h3C, 1'b1);
    send(1'b1, 7'h02, 8'hC3, 1'b0);
    wait_done();

    send(1'b1, 7'h33, 8'h77, 1'b0);
    repeat (49) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("abort_ncs", ncs, 1'b1);
    chk("abort_sclk", sclk, 1'b0);
    chk("abort_cmd_ready", cmd_ready, 1'b1);
    chk("abort_rsp_valid", rsp_valid, 1'b0);

    bad = 0;
    repeat (100) begin
      @(negedge clk);
      if (ncs !== 1'b1 || sclk !== 1'b0 || busy !== 1'b0 || rsp_valid !== 1'b0) bad++;
    end
    chk("idle_quiet", bad, 0);

    send(1'b1, 7'h05, 8'h5A, 1'b0);
    wait_done();
    send(1'b0, 7'h05, 8'h00, 1'b0);
    wait_done();

    for (int n = 0; n < 12; n++) begin
      keep = 1'($urandom);
      send(1'($urandom), 7'($urandom_range(0, 7)), 8'($urandom), keep);
      if (!keep) repeat ($urandom_range(0, 3)) @(posedge clk);
    end
    wait_done();
    chk("scoreboard_drained", 32'(q_t.size()), 32'd0);

    // CLK_DIV=1, CS_GAP=0 instance.
    cmd_rw_1 = 1'b1; cmd_addr_1 = 7'h7F; cmd_wdata_1 = 8'hFF; cmd_valid_1 = 1'b1;
    ok = 1'b0;
    t1 = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (cmd_ready_1) begin
        ok = 1'b1;
        t1 = cyc;
        break;
      end
    end
    if (!ok) timeout("d1_accept");
    @(posedge clk);
    #1 cmd_valid_1 = 1'b0;
    cmd_wdata_1 = 8'h00;
    fr = '0; nr = 0; last_rise = 0; bad = 0; prev_s = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (sclk_1 && !prev_s) begin
        fr = {fr[14:0], copi_1};
        if (nr > 0 && (cyc - last_rise) != 2) bad++;
        last_rise = cyc;
        nr++;
      end
      prev_s = sclk_1;
      if (cyc == t1 + 33) chk("d1_ncs_low_t33", ncs_1, 1'b0);
      if (cyc == t1 + 34) begin
        chk("d1_ncs_high_t34", ncs_1, 1'b1);
        chk("d1_rsp_valid_t34", rsp_valid_1, 1'b1);
        chk("d1_ready_t34", cmd_ready_1, 1'b1);
        chk("d1_rsp_rdata", rsp_rdata_1, 8'h00);
      end
    end
    chk("d1_frame", fr, 16'hFFFF);
    chk("d1_rises", nr, 16);
    chk("d1_sclk_period", bad, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1, "global timeout");
  end

endmodule : tb_spi_controller
`default_nettype wire
